// File: rtl/or32_checker.sv
// Response monitor for the 32-bit OR unit: two-stage golden a|b compare with
// saturating pass/fail counters, sticky error and first-failure capture.
module or32_checker #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned STOP_ON_FAIL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] f,
  input  logic             clear,
  output logic             res_valid,
  output logic             res_pass,
  output logic [WIDTH-1:0] mismatch,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             err,
  output logic [WIDTH-1:0] ff_a,
  output logic [WIDTH-1:0] ff_b,
  output logic [WIDTH-1:0] ff_f,
  output logic [CNT_W-1:0] ff_idx,
  output logic             halted
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HALT = 1'b1;

  logic [0:0]       state, state_nxt;
  logic             accept;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a, s1_b, s1_f;
  logic [CNT_W-1:0] s1_idx, idx;
  logic [WIDTH-1:0] mm_c;
  logic             fail_c;

  // State decodes are direct views of the state flop.
  assign in_ready = (state == RUN);
  assign halted   = (state == HALT);
  assign accept   = in_valid & in_ready & ~clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Golden compare of stage 1 and next-state logic.
  always_comb begin
    state_nxt = state;
    mm_c      = s1_f ^ (s1_a | s1_b);
    fail_c    = s1_valid && (mm_c != '0);
    if (clear)
      state_nxt = RUN;
    else if ((state == RUN) && fail_c && (STOP_ON_FAIL != 0))
      state_nxt = HALT;
  end

  // Stage 1: capture the accepted vector and its accept index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_f     <= '0;
      s1_idx   <= '0;
      idx      <= '0;
    end else if (clear) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_f     <= '0;
      s1_idx   <= '0;
      idx      <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_a   <= a;
        s1_b   <= b;
        s1_f   <= f;
        s1_idx <= idx;
        idx    <= idx + CNT_W'(1);
      end
    end
  end

  // Stage 2: result, saturating counters and first-failure capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid  <= 1'b0;
      res_pass   <= 1'b0;
      mismatch   <= '0;
      pass_count <= '0;
      fail_count <= '0;
      err        <= 1'b0;
      ff_a       <= '0;
      ff_b       <= '0;
      ff_f       <= '0;
      ff_idx     <= '0;
    end else if (clear) begin
      res_valid  <= 1'b0;
      res_pass   <= 1'b0;
      mismatch   <= '0;
      pass_count <= '0;
      fail_count <= '0;
      err        <= 1'b0;
      ff_a       <= '0;
      ff_b       <= '0;
      ff_f       <= '0;
      ff_idx     <= '0;
    end else begin
      res_valid <= s1_valid;
      if (s1_valid) begin
        res_pass <= ~fail_c;
        mismatch <= mm_c;
        if (!fail_c) begin
          if (pass_count != '1) pass_count <= pass_count + CNT_W'(1);
        end else begin
          if (fail_count != '1) fail_count <= fail_count + CNT_W'(1);
          if (!err) begin
            err    <= 1'b1;
            ff_a   <= s1_a;
            ff_b   <= s1_b;
            ff_f   <= s1_f;
            ff_idx <= s1_idx;
          end
        end
      end
    end
  end

endmodule
